mem_port_arbiter: RTL and testbench

- Shares the core's single 32-bit memory port between instruction fetch and the load/store path.
- Consumes decoded access controls from the decoder: mem_read/mem_write, mem_size (00=byte, 01=half, 10=word) and mem_unsigned.
- Owns byte-lane generation, store-data replication, load extraction with sign/zero extension, and misalignment faults.
- At most one memory transaction is outstanding.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_lsu_align.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_pkg;

    // Access size encoding as produced by the decoder; 2'b11 is illegal.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    // Owner of the in-flight transaction.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam logic [3:0] MEM_BE_ALL = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, data requester and memory port signals.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_rdata;
    logic              if_fault;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [1:0]        d_size;
    logic              d_unsigned;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              d_fault;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    // Arbiter side: serves the requesters and masters the memory port.
    modport master (
        input  if_req, if_addr,
        output if_done, if_rdata, if_fault,
        input  d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
        output d_done, d_rdata, d_fault,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    // Environment side: requesters plus memory.
    modport slave (
        output if_req, if_addr,
        input  if_done, if_rdata, if_fault,
        output d_req, d_we, d_addr, d_wdata, d_size, d_unsigned,
        input  d_done, d_rdata, d_fault,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_lsu_align.sv
// Byte-lane generation, store replication, load extraction and alignment check.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        fault
);

    logic [31:0] sh_s;

    // Decode lanes and extension for the current size and byte offset.
    always_comb begin
        sh_s = mem_rdata >> {addr_lo, 3'b000};
        case (size)
            BYTE: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = is_unsigned ? {24'h000000, sh_s[7:0]}
                                      : {{24{sh_s[7]}}, sh_s[7:0]};
                fault   = 1'b0;
            end
            HALF: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{st_data[15:0]}};
                ld_data = is_unsigned ? {16'h0000, sh_s[15:0]}
                                      : {{16{sh_s[15]}}, sh_s[15:0]};
                fault   = addr_lo[0];
            end
            WORD: begin
                be      = MEM_BE_ALL;
                wdata   = st_data;
                ld_data = mem_rdata;
                fault   = (addr_lo != 2'b00);
            end
            default: begin
                be      = 4'b0000;
                wdata   = st_data;
                ld_data = mem_rdata;
                fault   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_grant_q, last_grant_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              if_fault_q, if_fault_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              d_done_q, d_done_d;
    logic              d_fault_q, d_fault_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic              grant_data_s, grant_fetch_s, resp_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [1:0]        al_addr_s, al_size_s;
    logic              al_uns_s, al_fault_s;
    logic [3:0]        al_be_s;
    logic [31:0]       al_wdata_s, al_ld_s;

    // Arbitration and aligner input selection: live requester fields in IDLE, latched fields afterwards.
    always_comb begin
        grant_data_s  = bus.d_req & (~bus.if_req | ~RR_EN | (last_grant_q == FETCH));
        grant_fetch_s = bus.if_req & ~grant_data_s;
        sel_addr_s    = grant_data_s ? bus.d_addr : bus.if_addr;
        if (state_q == IDLE) begin
            al_addr_s = sel_addr_s[1:0];
            al_size_s = grant_data_s ? bus.d_size : WORD;
            al_uns_s  = grant_data_s ? bus.d_unsigned : 1'b0;
        end else begin
            al_addr_s = addr_lo_q;
            al_size_s = size_q;
            al_uns_s  = uns_q;
        end
        resp_s = ((state_q == ISSUE) & bus.mem_gnt & bus.mem_rvalid) |
                 ((state_q == WAIT) & bus.mem_rvalid);
    end

    lsu_align u_align (
        .addr_lo     (al_addr_s),
        .size        (al_size_s),
        .is_unsigned (al_uns_s),
        .st_data     (bus.d_wdata),
        .mem_rdata   (bus.mem_rdata),
        .be          (al_be_s),
        .wdata       (al_wdata_s),
        .ld_data     (al_ld_s),
        .fault       (al_fault_s)
    );

    // Next-state and registered-output computation for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        uns_d        = uns_q;
        we_d         = we_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        if_fault_d   = 1'b0;
        d_done_d     = 1'b0;
        d_fault_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_data_s | grant_fetch_s) begin
                    owner_d      = grant_data_s ? DATA : FETCH;
                    last_grant_d = grant_data_s ? DATA : FETCH;
                    addr_lo_d    = al_addr_s;
                    size_d       = al_size_s;
                    uns_d        = al_uns_s;
                    we_d         = grant_data_s & bus.d_we;
                    mem_we_d     = grant_data_s & bus.d_we;
                    mem_addr_d   = {sel_addr_s[ADDR_W-1:2], 2'b00};
                    mem_be_d     = al_be_s;
                    mem_wdata_d  = al_wdata_s;
                    if (al_fault_s) begin
                        state_d = RESP;
                        if (grant_data_s) begin
                            d_done_d  = 1'b1;
                            d_fault_d = 1'b1;
                            d_rdata_d = 32'h0000_0000;
                        end else begin
                            if_done_d  = 1'b1;
                            if_fault_d = 1'b1;
                            if_rdata_d = 32'h0000_0000;
                        end
                    end else begin
                        state_d   = ISSUE;
                        mem_req_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            WAIT: begin
                mem_req_d = 1'b0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        if (resp_s) begin
            state_d = RESP;
            if (owner_q == DATA) begin
                d_done_d = 1'b1;
                if (!we_q) begin
                    d_rdata_d = al_ld_s;
                end else begin
                    d_rdata_d = d_rdata_q;
                end
            end else begin
                if_done_d  = 1'b1;
                if_rdata_d = al_ld_s;
            end
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= FETCH;
            last_grant_q <= FETCH;
            addr_lo_q    <= 2'b00;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            if_done_q    <= 1'b0;
            if_fault_q   <= 1'b0;
            if_rdata_q   <= 32'h0000_0000;
            d_done_q     <= 1'b0;
            d_fault_q    <= 1'b0;
            d_rdata_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            we_q         <= we_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            if_done_q    <= if_done_d;
            if_fault_q   <= if_fault_d;
            if_rdata_q   <= if_rdata_d;
            d_done_q     <= d_done_d;
            d_fault_q    <= d_fault_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_fault  = if_fault_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_fault   = d_fault_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (round-robin and fixed-priority builds).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        auto_resp = 1'b1;
    logic        man_gnt = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [31:0] rdata_v = 32'h0000_0000;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_port_arbiter_if #(.ADDR_W(32)) b0 ();
    mem_port_arbiter_if #(.ADDR_W(32)) b1 ();

    mem_port_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(b0));
    mem_port_arbiter #(.ADDR_W(32), .RR_EN(1'b0)) dut_pr (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    assign b0.mem_gnt    = auto_resp ? b0.mem_req : man_gnt;
    assign b0.mem_rvalid = auto_resp ? b0.mem_req : man_rvalid;
    assign b0.mem_rdata  = rdata_v;
    assign b1.mem_gnt    = b1.mem_req;
    assign b1.mem_rvalid = b1.mem_req;
    assign b1.mem_rdata  = 32'hCAFE_F00D;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic u);
        b0.d_we = we; b0.d_addr = a; b0.d_wdata = wd; b0.d_size = sz; b0.d_unsigned = u;
        b0.d_req = 1'b1;
    endtask

    // One complete data access with immediate gnt+rvalid; checks the issued beat and the response.
    task automatic do_d(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic u, input logic [31:0] rd,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata);
        rdata_v = rd;
        set_d(we, a, wd, sz, u);
        tick();
        check_eq({tag, "_mem_req"}, {31'd0, b0.mem_req}, 32'd1);
        check_eq({tag, "_mem_addr"}, b0.mem_addr, e_addr);
        check_eq({tag, "_mem_be"}, {28'd0, b0.mem_be}, {28'd0, e_be});
        check_eq({tag, "_mem_we"}, {31'd0, b0.mem_we}, {31'd0, we});
        if (we) check_eq({tag, "_mem_wdata"}, b0.mem_wdata, e_wdata);
        check_eq({tag, "_early_done"}, {31'd0, b0.d_done}, 32'd0);
        tick();
        check_eq({tag, "_done"}, {31'd0, b0.d_done}, 32'd1);
        check_eq({tag, "_fault"}, {31'd0, b0.d_fault}, 32'd0);
        if (!we) check_eq({tag, "_rdata"}, b0.d_rdata, e_rdata);
        b0.d_req = 1'b0;
        tick();
        check_eq({tag, "_done_pulse"}, {31'd0, b0.d_done}, 32'd0);
    endtask

    // Faulting data access: no memory request, done+fault one cycle after the request.
    task automatic do_dfault(input string tag, input logic [31:0] a, input logic [1:0] sz);
        set_d(1'b0, a, 32'h0, sz, 1'b0);
        tick();
        check_eq({tag, "_no_mem_req"}, {31'd0, b0.mem_req}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, b0.d_done}, 32'd1);
        check_eq({tag, "_fault"}, {31'd0, b0.d_fault}, 32'd1);
        check_eq({tag, "_rdata"}, b0.d_rdata, 32'h0);
        b0.d_req = 1'b0;
        tick();
        check_eq({tag, "_fault_clear"}, {30'd0, b0.d_done, b0.d_fault}, 32'd0);
    endtask

    initial begin
        logic seq [4];
        int   n_seen;
        int   d_cnt;
        int   f_cnt;
        b0.if_req = 1'b0; b0.if_addr = 32'h0; b0.d_req = 1'b0; b0.d_we = 1'b0;
        b0.d_addr = 32'h0; b0.d_wdata = 32'h0; b0.d_size = 2'b00; b0.d_unsigned = 1'b0;
        b1.if_req = 1'b0; b1.if_addr = 32'h0; b1.d_req = 1'b0; b1.d_we = 1'b0;
        b1.d_addr = 32'h0; b1.d_wdata = 32'h0; b1.d_size = 2'b10; b1.d_unsigned = 1'b0;
        #1;
        check_eq("reset_outputs", {26'd0, b0.mem_req, b0.mem_we, b0.d_done, b0.d_fault,
                                   b0.if_done, b0.if_fault}, 32'd0);
        check_eq("reset_d_rdata", b0.d_rdata, 32'h0);
        check_eq("reset_if_rdata", b0.if_rdata, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        do_d("word_ld", 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF,
             32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        check_eq("rdata_hold", b0.d_rdata, 32'hDEADBEEF);
        do_d("byte_ld_u", 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'h80112233,
             32'h100, 4'b1000, 32'h0, 32'h00000080);
        do_d("byte_ld_s", 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 32'h80112233,
             32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        do_d("half_ld_s", 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 32'h80112233,
             32'h100, 4'b1100, 32'h0, 32'hFFFF8011);
        do_d("half_st", 1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 32'h0,
             32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
        do_d("byte_st", 1'b1, 32'h101, 32'h0000005A, 2'b00, 1'b0, 32'h0,
             32'h100, 4'b0010, 32'h5A5A5A5A, 32'h0);

        do_dfault("mis_word", 32'h101, 2'b10);
        do_dfault("mis_half", 32'h203, 2'b01);
        do_dfault("bad_size", 32'h100, 2'b11);
        b0.if_addr = 32'h102; b0.if_req = 1'b1;
        tick();
        check_eq("if_mis_no_req", {31'd0, b0.mem_req}, 32'd0);
        check_eq("if_mis_done", {31'd0, b0.if_done}, 32'd1);
        check_eq("if_mis_fault", {31'd0, b0.if_fault}, 32'd1);
        b0.if_req = 1'b0;
        tick();
        check_eq("if_mis_clear", {30'd0, b0.if_done, b0.if_fault}, 32'd0);

        auto_resp = 1'b0;
        set_d(1'b0, 32'h300, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("gnt_wait_req_%0d", i), {31'd0, b0.mem_req}, 32'd1);
            check_eq($sformatf("gnt_wait_addr_%0d", i), b0.mem_addr, 32'h300);
        end
        man_gnt = 1'b1;
        tick();
        man_gnt = 1'b0;
        check_eq("wait_req_low", {31'd0, b0.mem_req}, 32'd0);
        check_eq("wait_no_done", {31'd0, b0.d_done}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("midrst_outputs", {26'd0, b0.mem_req, b0.mem_we, b0.d_done, b0.d_fault,
                                    b0.if_done, b0.if_fault}, 32'd0);
        check_eq("midrst_d_rdata", b0.d_rdata, 32'h0);
        check_eq("midrst_mem_be", {28'd0, b0.mem_be}, 32'd0);
        b0.d_req = 1'b0;
        tick(); tick();
        rst = 1'b0;
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        check_eq("stale_rvalid_d", {31'd0, b0.d_done}, 32'd0);
        check_eq("stale_rvalid_if", {31'd0, b0.if_done}, 32'd0);
        tick();
        check_eq("stale_rvalid_late", {30'd0, b0.d_done, b0.if_done}, 32'd0);

        auto_resp = 1'b1;
        rdata_v = 32'h12345678;
        b0.if_addr = 32'h400; b0.if_req = 1'b1;
        tick();
        check_eq("fetch_mem_addr", b0.mem_addr, 32'h400);
        check_eq("fetch_mem_be", {28'd0, b0.mem_be}, 32'hF);
        tick();
        check_eq("fetch_done", {31'd0, b0.if_done}, 32'd1);
        check_eq("fetch_rdata", b0.if_rdata, 32'h12345678);
        b0.if_req = 1'b0;
        tick();

        b0.if_addr = 32'h0; b0.if_req = 1'b1;
        set_d(1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
        n_seen = 0;
        for (int i = 0; i < 40 && n_seen < 4; i++) begin
            tick();
            if (b0.d_done || b0.if_done) begin
                check_eq("rr_single_done", {31'd0, b0.d_done & b0.if_done}, 32'd0);
                seq[n_seen] = b0.d_done;
                n_seen++;
            end
        end
        check_eq("rr_grant_count", n_seen, 32'd4);
        for (int i = 0; i < n_seen; i++) begin
            check_eq($sformatf("rr_owner_%0d", i), {31'd0, seq[i]}, {31'd0, ((i % 2) == 0)});
        end
        b0.if_req = 1'b0; b0.d_req = 1'b0;
        tick(); tick(); tick();

        b1.if_addr = 32'h40; b1.if_req = 1'b1;
        b1.d_addr = 32'h80; b1.d_req = 1'b1;
        d_cnt = 0; f_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (b1.d_done) d_cnt++;
            if (b1.if_done) f_cnt++;
        end
        check_eq("prio_no_fetch", f_cnt, 32'd0);
        check_eq("prio_data_served", {31'd0, d_cnt >= 5}, 32'd1);
        check_eq("prio_rdata", b1.d_rdata, 32'hCAFEF00D);
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
